// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
//   Load/store unit sitting between the core datapath and a handshaked data
//   bus. Each load or store becomes a single aligned 32-bit bus transaction
//   with byte enables. Load data is sign- or zero-extended before it is
//   returned to the datapath. The core is stalled while a transaction is
//   outstanding. Misaligned accesses and bus timeouts raise a one-cycle fault.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   mem_read, mem_write    load/store request; held stable while stall=1
//   funct3                 access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, write_data       byte address and LSB-aligned store data
//   read_data              extended load result; holds until the next load
//   stall                  freezes PC/RegWrite while the access is pending
//   fault                  one-cycle pulse in DONE on misalignment or timeout
//   bus_req/we/addr/be/wdata  request channel; bus_gnt accepts it
//   bus_rvalid/bus_rdata   read response, honoured only in WAIT
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          fault_q, fault_d;
  logic [1:0]    lane_q, lane_d;   // addr[1:0] of the access, for load lane select
  logic [2:0]    f3_q, f3_d;       // funct3 of the access, for load extension

  logic          req;
  logic          misal;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign req   = mem_read | mem_write;
  // Combinational so the very cycle the request appears is already stalled.
  assign stall = req & (state_q != S_DONE);

  // Size decode from funct3[1:0]: 00 byte, 01 half, otherwise word.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = write_data;
    misal      = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{write_data[15:0]}};
        misal      = addr[0];
      end
      default: begin
        misal = (addr[1:0] != 2'b00);
      end
    endcase
  end

  // Lane select and extension of the returned word.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    fault_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lane_d = addr[1:0];
          f3_d   = funct3;
          cnt_d  = '0;
          if (misal) begin
            // No bus traffic at all; report the fault directly from DONE.
            state_d     = S_DONE;
            fault_d     = 1'b1;
            read_data_d = '0;
          end else begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;   // store wins if both are raised
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
          end
        end
      end
      S_REQ: begin
        // A write completes on gnt. A read gnt only hands over to WAIT, so on
        // the last budget cycle the timeout takes priority over it.
        if (bus_gnt && bus_we_q) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          bus_req_d   = 1'b0;
          fault_d     = 1'b1;
          read_data_d = '0;
        end else if (bus_gnt) begin
          state_d   = S_WAIT;
          bus_req_d = 1'b0;
          cnt_d     = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          state_d     = S_DONE;
          read_data_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          fault_d     = 1'b1;
          read_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      lane_q      <= '0;
      f3_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
    end
  end

  assign read_data = read_data_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl. A driver issues loads/stores and pushes
// the expected bus request and expected completion into queues; a monitor pops
// and compares whenever a request rises or the access completes (DONE).
module tb_lsu_bus_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk, reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data, read_data;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } bus_exp_t;
  typedef struct { logic [31:0] rd; logic flt; int stall_cyc; } res_exp_t;

  bus_exp_t bq[$];
  res_exp_t rq[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  logic [31:0] mdl_rd = '0;   // model of the held read_data value

  // Bus responder configuration for the current transaction.
  int          cur_id = 0;
  int          cur_g  = 0;    // gnt after this many bus_req cycles (99 = never)
  int          cur_r  = 1;    // rvalid this many cycles after gnt
  bit          cur_rd = 1'b0;
  logic [31:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave model: grants after cur_g request cycles, returns read data
  // cur_r cycles after the grant, and sprinkles junk rvalid pulses whenever
  // no read response is pending (the DUT must ignore those).
  initial begin
    int req_cyc, rv_cnt, seen_id;
    bit gnt_done;
    req_cyc = 0; rv_cnt = 0; seen_id = 0; gnt_done = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (cur_id != seen_id) begin
        seen_id = cur_id; req_cyc = 0; rv_cnt = 0; gnt_done = 1'b0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata  = cur_rdata;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_rvalid = 1'b1;
      end
      if (bus_req && !gnt_done) begin
        if (req_cyc == cur_g) begin
          bus_gnt  = 1'b1;
          gnt_done = 1'b1;
          if (cur_rd) rv_cnt = cur_r;
        end
        req_cyc++;
      end else if (!bus_req) begin
        req_cyc  = 0;
        gnt_done = 1'b0;
      end
    end
  end

  // Monitor: compares request fields on bus_req rising and the completion
  // (read_data, fault, stall length) in the cycle where stall drops.
  initial begin
    bit prev_req;
    int stall_cnt;
    logic [31:0] last_rd;
    bus_exp_t be_e;
    res_exp_t re;
    prev_req = 1'b0; stall_cnt = 0; last_rd = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_req && !prev_req) begin
          if (bq.size() == 0) begin
            chk("unexpected_bus_req", 32'd1, 32'd0);
          end else begin
            be_e = bq.pop_front();
            chk("bus_addr", bus_addr, be_e.addr);
            chk("bus_be", {28'h0, bus_be}, {28'h0, be_e.be});
            chk("bus_wdata", bus_wdata, be_e.wdata);
            chk("bus_we", {31'h0, bus_we}, {31'h0, be_e.we});
          end
        end
        if ((mem_read || mem_write) && stall) begin
          stall_cnt++;
        end
        if ((mem_read || mem_write) && !stall) begin
          if (rq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            re = rq.pop_front();
            chk("done_read_data", read_data, re.rd);
            chk("done_fault", {31'h0, fault}, {31'h0, re.flt});
            chk("stall_cycles", stall_cnt, re.stall_cyc);
            chk("done_bus_req", {31'h0, bus_req}, 32'd0);
            last_rd = re.rd;
          end
          stall_cnt = 0;
        end else begin
          chk("fault_idle", {31'h0, fault}, 32'd0);
          chk("read_data_hold", read_data, last_rd);
        end
      end
      prev_req = bus_req;
    end
  end

  // Issue one access. Called just after a rising edge while the DUT is idle;
  // returns just after the rising edge that ends DONE, with inputs cleared.
  task automatic issue(input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int g, input int r);
    int nbytes, done_at;
    bit ok;
    bus_exp_t be_e;
    res_exp_t re;
    logic [31:0] v, mask;
    nbytes = 1 << f3[1:0];
    if ((a % nbytes) != 0) begin
      re.flt = 1'b1; re.rd = '0; re.stall_cyc = 1;
    end else begin
      be_e.addr = a & ~32'h3;
      be_e.we   = mw;
      be_e.be   = 4'(((1 << nbytes) - 1) << a[1:0]);
      for (int i = 0; i < 4; i++) be_e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      bq.push_back(be_e);
      done_at = mw ? g : g + r;   // index of the completing cycle since REQ entry
      if (done_at > TIMEOUT - 1) begin
        re.flt = 1'b1; re.rd = '0; re.stall_cyc = TIMEOUT + 1;
      end else begin
        re.flt = 1'b0; re.stall_cyc = done_at + 2;
        if (mw) begin
          re.rd = mdl_rd;
        end else begin
          v = rdat >> (8 * a[1:0]);
          if (nbytes < 4) begin
            mask = (32'h1 << (8 * nbytes)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
          end
          re.rd = v;
        end
      end
    end
    mdl_rd = re.rd;
    rq.push_back(re);

    cur_g = g; cur_r = r; cur_rd = !mw; cur_rdata = rdat; cur_id++;
    mem_read = mr; mem_write = mw; funct3 = f3; addr = a; write_data = wd;

    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL done_wait: no completion within 100 cycles at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    bit saw_rv;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'h0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'h0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_fault", {31'h0, fault}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);        // SW
    issue(0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, 1);        // SB
    issue(1, 0, 3'b000, 32'h301, 32'h0, 32'h12348067, 0, 2);        // LB
    issue(1, 0, 3'b100, 32'h301, 32'h0, 32'h12348067, 0, 2);        // LBU
    issue(1, 0, 3'b101, 32'h302, 32'h0, 32'h12348067, 0, 1);        // LHU
    issue(1, 0, 3'b001, 32'h302, 32'h0, 32'h8000FFFF, 2, 3);        // LH neg
    issue(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1);               // LW misaligned
    issue(1, 0, 3'b010, 32'h108, 32'h0, 32'h13572468, 0, 1);        // LW ok
    issue(0, 1, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 1);            // SH misaligned
    issue(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, 99, 1);              // LW, gnt never
    issue(1, 0, 3'b010, 32'h10C, 32'h0, 32'hA5A5A5A5, 5, 10);       // rvalid on last budget cycle
    issue(1, 0, 3'b010, 32'h110, 32'h0, 32'h5A5A5A5A, 5, 11);       // one cycle too late
    issue(0, 1, 3'b001, 32'h112, 32'hBEEF, 32'h0, 15, 1);           // gnt on last budget cycle
    issue(1, 1, 3'b001, 32'h116, 32'hCAFE, 32'h0, 0, 1);            // both high: store wins

    // Randomized traffic, mostly back-to-back with occasional gaps.
    for (int n = 0; n < 250; n++) begin
      bit is_st, both;
      logic [2:0] f3;
      int g, r;
      is_st = $urandom_range(0, 1);
      both  = is_st && ($urandom_range(0, 7) == 0);
      f3    = is_st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      g     = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
      r     = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 3);
      issue(!is_st || both, is_st, f3, $urandom, $urandom, $urandom, g, r);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_drained", bq.size(), 32'd0);
    chk("res_queue_drained", rq.size(), 32'd0);

    // Reset in the middle of a read; the late rvalid must not land anywhere.
    mon_en = 1'b0;
    cur_g = 0; cur_r = 10; cur_rd = 1'b1; cur_rdata = 32'hCAFEF00D; cur_id++;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;   // REQ, granted this cycle
    @(posedge clk); #1;   // WAIT
    @(negedge clk);
    chk("wait_stall", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bus_req", {31'h0, bus_req}, 32'd0);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk("mid_rst_bus_be", {28'h0, bus_be}, 32'd0);
    chk("mid_rst_read_data", read_data, 32'd0);
    chk("mid_rst_fault", {31'h0, fault}, 32'd0);
    chk("mid_rst_stall_req", {31'h0, stall}, 32'd1);
    mem_read = 1'b0;
    #1;
    chk("mid_rst_stall_noreq", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_rv = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus_rvalid && bus_rdata == 32'hCAFEF00D) saw_rv = 1'b1;
    end
    chk("late_rvalid_seen", {31'h0, saw_rv}, 32'd1);
    chk("late_rvalid_read_data", read_data, 32'd0);
    chk("late_rvalid_bus_req", {31'h0, bus_req}, 32'd0);
    chk("late_rvalid_fault", {31'h0, fault}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit between the core datapath and a handshaked data bus. It takes the ALU address, store data and funct3 from the datapath, runs one aligned 32-bit bus transaction with byte enables, and returns sign- or zero-extended load data to the datapath's ReadData input. While a transaction is in flight it holds the core in a stall so PC and register writes freeze. It also detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, maximum cycles spent in REQ plus WAIT before aborting with fault.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mem_read  in  1  current instruction is a load; held stable while stall=1.
mem_write  in  1  current instruction is a store; held stable while stall=1.
funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010).
addr  in  32  byte address (ALUResult).
write_data  in  32  store data (rs2), LSB-aligned.
read_data  out  32  extended load result to datapath ReadData.
stall  out  1  freeze PC and RegWrite this cycle.
fault  out  1  one-cycle pulse: misaligned access or timeout.
bus_req  out  1  request valid.
bus_we  out  1  1 = write.
bus_addr  out  32  word address, addr[1:0] forced to 00.
bus_be  out  4  byte enables.
bus_wdata  out  32  store data replicated into lanes.
bus_gnt  in  1  request accepted this cycle.
bus_rvalid  in  1  read data valid this cycle.
bus_rdata  in  32  read data word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset: IDLE; all bus outputs, read_data, fault and timeout counter are 0.
- stall = (mem_read|mem_write) & (state != DONE). This is combinational, so the request cycle stalls immediately.
- IDLE, no request: stay in IDLE.
- IDLE, request, aligned: register the following and go to REQ.
  - bus_addr = {addr[31:2],2'b00}.
  - bus_we = mem_write. If mem_read and mem_write are both high, mem_write wins.
  - bus_be: byte = 1<<addr[1:0]; half = 0011 or 1100 selected by addr[1]; word = 1111.
  - bus_wdata: byte = {4{wd[7:0]}}; half = {2{wd[15:0]}}; word = wd.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠00. On misalignment go straight to DONE with no bus activity, fault=1 and read_data=0.
- REQ: bus_req held at 1. When bus_gnt=1, deassert bus_req the next cycle. A write then goes to DONE; a read goes to WAIT.
- WAIT: when bus_rvalid=1, register the extended result and go to DONE.
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - bus_rvalid outside WAIT is ignored.
- Timeout counter: clears on leaving IDLE and increments each cycle in REQ or WAIT. When it reaches TIMEOUT-1 without completion, go to DONE with fault=1, read_data=0, bus_req=0.
- DONE: lasts exactly one cycle. stall=0 and read_data is valid, so the core commits at the end of this cycle. Then return to IDLE.
  - read_data holds its value until the next load completes.
  - fault is 1 only during DONE, and only for the fault cases.
- Latency: a store with gnt in the first REQ cycle gives stall for 2 cycles. A load with gnt in REQ and rvalid one cycle later gives stall for 3 cycles.
- Back-to-back accesses: after DONE the FSM passes through IDLE for one cycle. The next instruction's request is sampled there, so stall is asserted again from that IDLE cycle on.
- Asynchronous reset mid-transaction returns to IDLE at once with bus_req=0. A later rvalid is ignored.

Test Plan:
- SW addr=0x100, wd=0xDEADBEEF, gnt immediate -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high 2 cycles; fault=0.
- SB addr=0x203, wd=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, bus_addr=0x200.
- LB addr=0x301, rdata=0x12348067, rvalid 2 cycles after gnt -> read_data=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr=0x302 -> 0x00001234.
- LW addr=0x102 -> no bus_req, fault pulses 1 cycle, read_data=0, stall high 1 cycle. SH addr=0x101 gives the same response.
- LW with gnt never asserted, TIMEOUT=16 -> fault in DONE 16 cycles after REQ entry, bus_req drops, FSM returns to IDLE.
- Assert reset during WAIT, then drive rvalid=1 -> outputs 0, state IDLE, stall follows only mem_read/mem_write, no read_data update.
